// File: rtl/bsk_bus_pkg.sv
// Shared types and constants for the BSK parallel bus master.
// Provides FSM/owner enums, PRD register map, timer width, load helper.
package bsk_bus_pkg;

    // Phase timers only ever hold T_x-1 with T_x in 1..15.
    localparam int TMR_W = 4;

    // PRD command board register map.
    localparam logic [1:0] ADR_COM_LO = 2'd0;
    localparam logic [1:0] ADR_COM_HI = 2'd1;
    localparam logic [1:0] ADR_IND    = 2'd2;
    localparam logic [1:0] ADR_VER    = 2'd3;

    localparam logic [3:0] CS_PRD       = 4'b1011;
    localparam logic [7:0] PRD_PASSWORD = 8'hA4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_e;

    // Who owns the transaction currently on the bus.
    typedef enum logic [1:0] {
        OWN_USER,
        OWN_POLL0,
        OWN_POLL1
    } own_e;

    function automatic logic [TMR_W-1:0] tmr_load(input int unsigned n);
        return TMR_W'(n - 1);
    endfunction

endpackage

// File: rtl/bsk_bus_master_if.sv
// Request port plus bus control lines of the BSK bus master.
// master: the initiator (bsk_bus_master); slave: host/peripheral side.
interface bsk_bus_master_if;

    // local request side
    logic        iReq;
    logic        iWe;
    logic [3:0]  iCsSel;
    logic [1:0]  iAdr;
    logic [15:0] iWrData;
    logic        oBusy;
    logic        oDone;
    logic [15:0] oRdData;

    // bus control lines (data lines are a separate inout)
    logic [1:0]  oA;
    logic [3:0]  oCS;
    logic        oRd;
    logic        oWr;

    modport master (
        input  iReq,
        input  iWe,
        input  iCsSel,
        input  iAdr,
        input  iWrData,
        output oBusy,
        output oDone,
        output oRdData,
        output oA,
        output oCS,
        output oRd,
        output oWr
    );

    modport slave (
        output iReq,
        output iWe,
        output iCsSel,
        output iAdr,
        output iWrData,
        input  oBusy,
        input  oDone,
        input  oRdData,
        input  oA,
        input  oCS,
        input  oRd,
        input  oWr
    );

endinterface

// File: rtl/bsk_nibble_check.sv
// Complement-coded command byte decoder.
// byte_i: raw byte; valid_o: hi nibble == ~lo nibble; nib_o: lo nibble.
module bsk_nibble_check (
    input  logic [7:0] byte_i,
    output logic       valid_o,
    output logic [3:0] nib_o
);

    assign valid_o = (byte_i[7:4] == ~byte_i[3:0]);
    assign nib_o   = byte_i[3:0];

endmodule

// File: rtl/bsk_bus_master.sv
// BSK parallel bus initiator: user single transfers + PRD command polling.
// Ports: clk, iRes (sync, active-high), bus (request + oA/oCS/oRd/oWr),
// bD (16-bit tri-state data), oCom/oComErr (validated polled command).
module bsk_bus_master
    import bsk_bus_pkg::*;
#(
    parameter int unsigned T_SETUP     = 2,
    parameter int unsigned T_STROBE    = 4,
    parameter int unsigned T_HOLD      = 2,
    parameter int unsigned POLL_PERIOD = 2000,
    parameter logic [3:0]  POLL_CS     = CS_PRD,
    parameter logic [3:0]  IDLE_CS     = 4'b0000
) (
    input  logic              clk,
    input  logic              iRes,
    bsk_bus_master_if.master  bus,
    output logic [15:0]       oCom,
    output logic              oComErr,
    inout  wire  [15:0]       bD
);

    localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [PW-1:0] POLL_MAX = PW'(POLL_PERIOD - 1);

    state_e             state_q;
    own_e               own_q;
    logic [TMR_W-1:0]   tmr_q;
    logic               pend_q;
    logic               we_q;
    logic               drv_q;
    logic [15:0]        wdat_q;
    logic [3:0]         cs_q;
    logic [1:0]         adr_q;
    logic               rd_q;
    logic               wr_q;
    logic               busy_q;
    logic               done_q;
    logic [15:0]        rdat_q;
    logic [15:0]        shadow_q;
    logic               err_q;
    logic [15:0]        com_q;
    logic               comerr_q;
    logic [PW-1:0]      poll_q;
    logic [PW-1:0]      poll_d;

    logic               poll_due;
    logic               go;
    own_e               go_own;
    logic               go_we;
    logic [3:0]         go_cs;
    logic [1:0]         go_adr;

    logic               lo_ok;
    logic               hi_ok;
    logic [3:0]         lo_nib;
    logic [3:0]         hi_nib;
    logic               word_ok;

    bsk_nibble_check u_chk_lo (
        .byte_i  (bD[7:0]),
        .valid_o (lo_ok),
        .nib_o   (lo_nib)
    );

    bsk_nibble_check u_chk_hi (
        .byte_i  (bD[15:8]),
        .valid_o (hi_ok),
        .nib_o   (hi_nib)
    );

    assign word_ok  = lo_ok & hi_ok;
    assign poll_due = (POLL_PERIOD != 0) && (poll_q == POLL_MAX);

    // IDLE arbitration. A pending second poll read outranks the user so
    // the pair is never split; otherwise the user outranks a due poll.
    always_comb begin
        go     = 1'b0;
        go_own = OWN_USER;
        go_we  = 1'b0;
        go_cs  = POLL_CS;
        go_adr = ADR_COM_LO;
        if (state_q == ST_IDLE) begin
            if (pend_q) begin
                go     = 1'b1;
                go_own = OWN_POLL1;
                go_adr = ADR_COM_HI;
            end else if (bus.iReq) begin
                go     = 1'b1;
                go_we  = bus.iWe;
                go_cs  = bus.iCsSel;
                go_adr = bus.iAdr;
            end else if (poll_due) begin
                go     = 1'b1;
                go_own = OWN_POLL0;
            end
        end
    end

    // Poll timer free-runs and saturates at "due"; only a pair start
    // clears it, so a user transfer merely delays a due poll.
    always_comb begin
        poll_d = poll_q;
        if (go && (go_own == OWN_POLL0)) begin
            poll_d = '0;
        end else if (poll_q != POLL_MAX) begin
            poll_d = poll_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (iRes) begin
            poll_q <= '0;
        end else begin
            poll_q <= poll_d;
        end
    end

    always_ff @(posedge clk) begin
        if (iRes) begin
            state_q  <= ST_IDLE;
            own_q    <= OWN_USER;
            tmr_q    <= '0;
            pend_q   <= 1'b0;
            we_q     <= 1'b0;
            drv_q    <= 1'b0;
            wdat_q   <= '0;
            cs_q     <= IDLE_CS;
            adr_q    <= '0;
            rd_q     <= 1'b1;
            wr_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rdat_q   <= '0;
            shadow_q <= '0;
            err_q    <= 1'b0;
            com_q    <= '0;
            comerr_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        state_q <= ST_SETUP;
                        tmr_q   <= tmr_load(T_SETUP);
                        own_q   <= go_own;
                        we_q    <= go_we;
                        drv_q   <= go_we;
                        wdat_q  <= bus.iWrData;
                        cs_q    <= go_cs;
                        adr_q   <= go_adr;
                        busy_q  <= 1'b1;
                        if (go_own == OWN_POLL1) begin
                            pend_q <= 1'b0;
                        end
                    end
                end
                ST_SETUP: begin
                    if (tmr_q == '0) begin
                        state_q <= ST_STROBE;
                        tmr_q   <= tmr_load(T_STROBE);
                        rd_q    <= we_q;
                        wr_q    <= ~we_q;
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                ST_STROBE: begin
                    if (tmr_q == '0) begin
                        state_q <= ST_HOLD;
                        tmr_q   <= tmr_load(T_HOLD);
                        rd_q    <= 1'b1;
                        wr_q    <= 1'b1;
                        // Read data is taken on the strobe's rising edge.
                        if (!we_q) begin
                            unique case (own_q)
                                OWN_USER: begin
                                    rdat_q <= bD;
                                end
                                OWN_POLL0: begin
                                    if (word_ok) begin
                                        shadow_q[7:0] <= {hi_nib, lo_nib};
                                    end
                                    err_q <= ~word_ok;
                                end
                                OWN_POLL1: begin
                                    if (word_ok) begin
                                        shadow_q[15:8] <= {hi_nib, lo_nib};
                                    end
                                    err_q <= err_q | ~word_ok;
                                end
                                default: ;
                            endcase
                        end
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (tmr_q == '0) begin
                        state_q <= ST_IDLE;
                        cs_q    <= IDLE_CS;
                        adr_q   <= '0;
                        drv_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        unique case (own_q)
                            OWN_USER:  done_q <= 1'b1;
                            OWN_POLL0: pend_q <= 1'b1;
                            OWN_POLL1: begin
                                com_q    <= shadow_q;
                                comerr_q <= err_q;
                            end
                            default: ;
                        endcase
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
            endcase
        end
    end

    assign bD          = drv_q ? wdat_q : 16'hzzzz;
    assign bus.oBusy   = busy_q;
    assign bus.oDone   = done_q;
    assign bus.oRdData = rdat_q;
    assign bus.oA      = adr_q;
    assign bus.oCS     = cs_q;
    assign bus.oRd     = rd_q;
    assign bus.oWr     = wr_q;
    assign oCom        = com_q;
    assign oComErr     = comerr_q;

endmodule

// File: tb/tb_bsk_bus_master.sv
// Directed bench for bsk_bus_master: user transfer vectors, PRD polling,
// arbitration corner cases and reset in the middle of a write strobe.
module tb_bsk_bus_master;
    import bsk_bus_pkg::*;

    logic        clk = 1'b0;
    logic        iRes;
    wire  [15:0] bD;
    logic [15:0] oCom;
    logic        oComErr;

    bsk_bus_master_if bus ();

    bsk_bus_master dut (
        .clk     (clk),
        .iRes    (iRes),
        .bus     (bus),
        .oCom    (oCom),
        .oComErr (oComErr),
        .bD      (bD)
    );

    always #5 clk = ~clk;

    // Peripheral model: answers reads while oRd is low; "park" drives 0
    // otherwise so any DUT drive on a read shows up on bD.
    logic        park;
    logic [15:0] poll_d0;
    logic [15:0] poll_d1;
    logic [15:0] user_rd;
    logic [15:0] mdl_d;

    always_comb begin
        mdl_d = 16'h0000;
        if (!bus.oRd) begin
            if (bus.oCS == CS_PRD && bus.oA == ADR_COM_LO) begin
                mdl_d = poll_d0;
            end else if (bus.oCS == CS_PRD && bus.oA == ADR_COM_HI) begin
                mdl_d = poll_d1;
            end else begin
                mdl_d = user_rd;
            end
        end
    end

    assign bD = (park || !bus.oRd) ? mdl_d : 16'hzzzz;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [9:0] snap();
        return {bus.oBusy, bus.oDone, bus.oCS, bus.oA, bus.oRd, bus.oWr};
    endfunction

    task automatic wait_poll(input int limit, output int t);
        int n;
        n = 0;
        while (!(bus.oCS == CS_PRD && bus.oA == ADR_COM_LO && bus.oBusy)
               && n < limit) begin
            tick();
            n++;
        end
        chk("poll_start_seen", 32'(n < limit), 1);
        t = cyc;
    endtask

    task automatic wait_done(input int limit, input string nm);
        int n;
        n = 0;
        while (!bus.oDone && n < limit) begin
            tick();
            n++;
        end
        chk(nm, 32'(n < limit), 1);
    endtask

    // Called in the first cycle of poll read 0 (t0).
    task automatic pair_check(input int t0, input logic [15:0] prev,
                              input logic [15:0] exp_com,
                              input logic exp_err, input string tag);
        int dn;
        dn = 0;
        while (cyc < t0 + 8) begin
            tick();
            dn += int'(bus.oDone);
        end
        chk({tag, "_gap"}, {bus.oBusy, bus.oCS}, 5'h00);
        tick();
        dn += int'(bus.oDone);
        chk({tag, "_rd1"}, {bus.oBusy, bus.oCS, bus.oA},
            {1'b1, CS_PRD, ADR_COM_HI});
        while (cyc < t0 + 16) begin
            tick();
            dn += int'(bus.oDone);
        end
        chk({tag, "_com_hold"}, oCom, prev);
        tick();
        dn += int'(bus.oDone);
        chk({tag, "_busy_end"}, bus.oBusy, 0);
        chk({tag, "_com"}, oCom, exp_com);
        chk({tag, "_err"}, oComErr, exp_err);
        chk({tag, "_no_done"}, dn, 0);
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  cs;
        logic [1:0]  adr;
        logic [15:0] wd;
        logic [15:0] rd_bus;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vt [6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int tp;
        logic [9:0] es;
        logic strb;

        vt[0] = '{1'b1, CS_PRD, ADR_IND, 16'h00A5, 16'h0000, 16'h0000};
        vt[1] = '{1'b0, CS_PRD, ADR_VER, 16'h5555, 16'hA44B, 16'hA44B};
        vt[2] = '{1'b1, 4'h5, 2'd1, {8'h00, PRD_PASSWORD}, 16'h0, 16'hA44B};
        vt[3] = '{1'b0, 4'h2, 2'd0, 16'hFFFF, 16'h0000, 16'h0000};
        vt[4] = '{1'b0, 4'hF, 2'd1, 16'h0F0F, 16'h1234, 16'h1234};
        vt[5] = '{1'b1, 4'h1, 2'd3, 16'h8001, 16'h0000, 16'h1234};

        iRes        = 1'b1;
        bus.iReq    = 1'b0;
        bus.iWe     = 1'b0;
        bus.iCsSel  = 4'h0;
        bus.iAdr    = 2'd0;
        bus.iWrData = 16'h0;
        park        = 1'b1;
        poll_d0     = 16'h0;
        poll_d1     = 16'h0;
        user_rd     = 16'h0;

        tick();
        tick();
        chk("rst_bus", snap(), {1'b0, 1'b0, 4'h0, 2'd0, 1'b1, 1'b1});
        chk("rst_rdata", bus.oRdData, 16'h0);
        chk("rst_com", oCom, 16'h0);
        chk("rst_err", oComErr, 0);
        chk("rst_bD", bD, 16'h0);
        iRes = 1'b0;

        // user transfers: 9 cycles from iReq to oDone
        for (int i = 0; i < 6; i++) begin
            bus.iWe     = vt[i].we;
            bus.iCsSel  = vt[i].cs;
            bus.iAdr    = vt[i].adr;
            bus.iWrData = vt[i].wd;
            user_rd     = vt[i].rd_bus;
            park        = !vt[i].we;
            bus.iReq    = 1'b1;
            for (int k = 1; k <= 9; k++) begin
                tick();
                if (k == 1) bus.iReq = 1'b0;
                strb = (k >= 3 && k <= 6);
                es = {k <= 8, k == 9,
                      (k <= 8) ? vt[i].cs : 4'h0,
                      (k <= 8) ? vt[i].adr : 2'd0,
                      !(strb && !vt[i].we), !(strb && vt[i].we)};
                chk($sformatf("v%0d_c%0d_bus", i, k), snap(), es);
                if (k <= 8) begin
                    chk($sformatf("v%0d_c%0d_bD", i, k), bD,
                        vt[i].we ? vt[i].wd
                                 : (strb ? vt[i].rd_bus : 16'h0));
                end
            end
            park = 1'b1;
            #1;
            chk($sformatf("v%0d_bD_free", i), bD, 16'h0);
            chk($sformatf("v%0d_rdata", i), bus.oRdData, vt[i].exp_rd);
        end
        park = 1'b0;

        // clean poll pair
        poll_d0 = 16'h3CF0;
        poll_d1 = 16'h96E1;
        wait_poll(2100, t0);
        pair_check(t0, 16'h0000, 16'h61C0, 1'b0, "pollA");

        // corrupted low byte at adr0: com[7:0] kept, com[15:8] updated
        poll_d0 = 16'h3CF1;
        poll_d1 = 16'h87D2;
        tp = t0;
        wait_poll(2100, t0);
        chk("poll_period", t0 - tp, 2000);
        pair_check(t0, 16'h61C0, 16'h72C0, 1'b1, "pollB");

        // user request in the very cycle the poll becomes due
        poll_d0 = 16'h3CF0;
        poll_d1 = 16'h96E1;
        while (cyc < t0 + 1999) tick();
        bus.iWe     = 1'b0;
        bus.iCsSel  = 4'h5;
        bus.iAdr    = 2'd2;
        bus.iWrData = 16'h0;
        user_rd     = 16'h7E57;
        bus.iReq    = 1'b1;
        tp = cyc;
        tick();
        bus.iReq = 1'b0;
        chk("arb_user_first", {bus.oCS, bus.oA}, {4'h5, 2'd2});
        wait_done(20, "arb_done_seen");
        chk("arb_latency", cyc - tp, 9);
        chk("arb_rdata", bus.oRdData, 16'h7E57);
        tick();
        chk("arb_poll_after", {bus.oBusy, bus.oCS, bus.oA},
            {1'b1, CS_PRD, ADR_COM_LO});
        t0 = cyc;
        pair_check(t0, 16'h72C0, 16'h61C0, 1'b0, "pollC");

        // request arriving between poll reads; floating bus at adr1
        poll_d0 = 16'h5AA5;
        poll_d1 = 16'hFFFF;
        wait_poll(2100, t0);
        while (cyc < t0 + 3) tick();
        bus.iWe     = 1'b1;
        bus.iCsSel  = 4'h6;
        bus.iAdr    = 2'd1;
        bus.iWrData = 16'hC3C3;
        bus.iReq    = 1'b1;
        while (cyc < t0 + 8) tick();
        chk("mid_gap", {bus.oBusy, bus.oCS}, 5'h00);
        tick();
        chk("mid_rd1", {bus.oBusy, bus.oCS, bus.oA},
            {1'b1, CS_PRD, ADR_COM_HI});
        while (cyc < t0 + 17) tick();
        chk("mid_busy_end", bus.oBusy, 0);
        chk("mid_com", oCom, 16'h61A5);
        chk("mid_err", oComErr, 1);
        tick();
        bus.iReq = 1'b0;
        chk("mid_user", {bus.oBusy, bus.oCS, bus.oA}, {1'b1, 4'h6, 2'd1});
        chk("mid_user_bD", bD, 16'hC3C3);
        wait_done(20, "mid_done_seen");
        chk("mid_done_time", cyc - t0, 26);

        // reset during the strobe of a write
        tick();
        bus.iWe     = 1'b1;
        bus.iCsSel  = CS_PRD;
        bus.iAdr    = ADR_IND;
        bus.iWrData = 16'h00A5;
        bus.iReq    = 1'b1;
        tick();
        bus.iReq = 1'b0;
        tp = 0;
        while (bus.oWr && tp < 10) begin
            tick();
            tp++;
        end
        chk("rw_strobe_seen", 32'(tp < 10), 1);
        iRes = 1'b1;
        tick();
        iRes = 1'b0;
        park = 1'b1;
        #1;
        chk("rw_bus", snap(), {1'b0, 1'b0, 4'h0, 2'd0, 1'b1, 1'b1});
        chk("rw_bD", bD, 16'h0);
        chk("rw_com", {oCom, oComErr}, 17'h0);
        chk("rw_rdata", bus.oRdData, 16'h0);
        tp = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            tp += int'(bus.oDone) + int'(bus.oBusy);
        end
        chk("rw_quiet", tp, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
